seq_mem_arb2: RTL and testbench

- Two-requester round-robin arbiter sharing one single-port sequential memory (one-cycle read/write, read and write mutually exclusive, one-cycle done pulses).
- Serialises requests so the memory never sees read_en and write_en together.
- Rejects out-of-range addresses locally.
- Returns per-requester responses.
- Sits between the compute units and the memory instance in the generated design.

---
 rtl/seq_mem_arb_pkg.sv | 8 +
 rtl/seq_mem_arb2_rr_pick2.sv | 19 +
 rtl/seq_mem_arb2.sv | 156 +++++++++++++++
 tb/tb_seq_mem_arb2.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mem_arb_pkg.sv
// rtl/seq_mem_arb_pkg.sv - shared types for the two-port sequential memory arbiter
package seq_mem_arb_pkg;
    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

    typedef logic port_idx_t;
endpackage

// File: rtl/seq_mem_arb2_rr_pick2.sv
// rtl/seq_mem_arb2_rr_pick2.sv - combinational two-way round-robin pick
module rr_pick2
    import seq_mem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  port_idx_t  last,
    output logic       grant_vld,
    output port_idx_t  grant_idx
);
    // Under contention the port that did not win last time goes next.
    always_comb begin
        grant_vld = |valid;
        if (valid == 2'b11) begin
            grant_idx = ~last;
        end else begin
            grant_idx = valid[1];
        end
    end
endmodule

// File: rtl/seq_mem_arb2.sv
// rtl/seq_mem_arb2.sv - two-requester round-robin arbiter in front of a single-port memory
module seq_mem_arb2
    import seq_mem_arb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 16,
    parameter int IDX_SIZE = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          req_valid,
    output logic [NUM_PORTS-1:0]          req_ready,
    input  logic [NUM_PORTS-1:0]          req_write,
    input  logic [NUM_PORTS*IDX_SIZE-1:0] req_addr,
    input  logic [NUM_PORTS*WIDTH-1:0]    req_wdata,
    output logic [NUM_PORTS-1:0]          resp_valid,
    output logic                          resp_err,
    output logic [WIDTH-1:0]              resp_rdata,
    output logic [IDX_SIZE-1:0]           mem_addr0,
    output logic                          mem_read_en,
    output logic                          mem_write_en,
    output logic [WIDTH-1:0]              mem_in,
    input  logic [WIDTH-1:0]              mem_out,
    input  logic                          mem_read_done,
    input  logic                          mem_write_done,
    output logic                          busy
);
    arb_state_t           state_q, state_d;
    port_idx_t            last_q, last_d;
    port_idx_t            port_q, port_d;
    logic                 write_q, write_d;
    logic                 err_q, err_d;
    logic                 rd_en_q, rd_en_d;
    logic                 wr_en_q, wr_en_d;
    logic [IDX_SIZE-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]     wdata_q, wdata_d;
    logic [WIDTH-1:0]     rdata_q, rdata_d;
    logic [NUM_PORTS-1:0] resp_valid_q, resp_valid_d;

    logic                 grant_vld;
    port_idx_t            grant_idx;
    logic [IDX_SIZE-1:0]  sel_addr;
    logic [WIDTH-1:0]     sel_wdata;
    logic                 sel_write;
    logic                 addr_ok;

    rr_pick2 u_pick (
        .valid     (req_valid),
        .last      (last_q),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    assign sel_addr  = grant_idx ? req_addr[IDX_SIZE +: IDX_SIZE] : req_addr[0 +: IDX_SIZE];
    assign sel_wdata = grant_idx ? req_wdata[WIDTH +: WIDTH] : req_wdata[0 +: WIDTH];
    assign sel_write = req_write[grant_idx];
    assign addr_ok   = 32'(sel_addr) < SIZE;

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Enables and response pulses are computed one state ahead so they come out of flops.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        port_d       = port_q;
        write_d      = write_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        rd_en_d      = 1'b0;
        wr_en_d      = 1'b0;
        resp_valid_d = '0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    port_d  = grant_idx;
                    last_d  = grant_idx;
                    write_d = sel_write;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    if (addr_ok) begin
                        err_d   = 1'b0;
                        rd_en_d = ~sel_write;
                        wr_en_d = sel_write;
                        state_d = ISSUE;
                    end else begin
                        err_d                   = 1'b1;
                        resp_valid_d[grant_idx] = 1'b1;
                        state_d                 = RESP;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_read_done || mem_write_done) begin
                    if (!write_q) begin
                        rdata_d = mem_out;
                    end
                    resp_valid_d[port_q] = 1'b1;
                    state_d              = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            port_q       <= 1'b0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            resp_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            port_q       <= port_d;
            write_q      <= write_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_err     = err_q;
    assign resp_rdata   = rdata_q;
    assign mem_addr0    = addr_q;
    assign mem_in       = wdata_q;
    assign mem_read_en  = rd_en_q;
    assign mem_write_en = wr_en_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_seq_mem_arb2.sv
// tb/tb_seq_mem_arb2.sv - randomized scoreboard bench for seq_mem_arb2
module tb_seq_mem_arb2;
    localparam int WIDTH = 32;
    localparam int SIZE  = 12;
    localparam int IDX   = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [1:0]       req_write = '0;
    logic [2*IDX-1:0] req_addr = '0;
    logic [2*WIDTH-1:0] req_wdata = '0;
    logic [1:0]       resp_valid;
    logic             resp_err;
    logic [WIDTH-1:0] resp_rdata;
    logic [IDX-1:0]   mem_addr0;
    logic             mem_read_en, mem_write_en;
    logic [WIDTH-1:0] mem_in;
    logic [WIDTH-1:0] mem_out = '0;
    logic             mem_read_done = 1'b0, mem_write_done = 1'b0;
    logic             busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    seq_mem_arb2 #(.WIDTH(WIDTH), .SIZE(SIZE), .IDX_SIZE(IDX)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_addr0(mem_addr0), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_in(mem_in), .mem_out(mem_out),
        .mem_read_done(mem_read_done), .mem_write_done(mem_write_done),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port memory with one-cycle done pulses.
    logic [WIDTH-1:0] mem [16];
    always @(posedge clk) begin
        mem_read_done  <= 1'b0;
        mem_write_done <= 1'b0;
        if (mem_write_en) begin
            mem[mem_addr0] <= mem_in;
            mem_write_done <= 1'b1;
        end
        if (mem_read_en) begin
            mem_out       <= mem[mem_addr0];
            mem_read_done <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model state.
    typedef struct {
        int               port;
        bit               err;
        bit               is_rd;
        logic [WIDTH-1:0] data;
        int               due;
    } exp_t;
    exp_t             sb[$];
    logic [WIDTH-1:0] ref_mem [16];
    int               m_last = 1;
    int               m_free = 0;
    int               iss_cyc = -10;
    bit               iss_wr = 1'b0;
    logic [IDX-1:0]   iss_addr = '0;
    logic [WIDTH-1:0] iss_data = '0;
    bit               post_rst = 1'b1;

    // Requester state.
    bit               act[2];
    bit               acc[2];
    bit               wr[2];
    logic [IDX-1:0]   ad[2];
    logic [WIDTH-1:0] wd[2];

    function automatic bit want(input int i, input int mode);
        case (mode)
            0: return 1'b1;
            1: return i == 1;
            2: return $urandom_range(2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive();
        req_valid = {act[1], act[0]};
        req_write = {wr[1], wr[0]};
        req_addr  = {ad[1], ad[0]};
        req_wdata = {wd[1], wd[0]};
    endtask

    task automatic model_step(input bit rst);
        bit         e_rd, e_wr;
        logic [1:0] exp_ready;
        int         g;
        e_rd = (cyc == iss_cyc) && !iss_wr;
        e_wr = (cyc == iss_cyc) && iss_wr;
        chk("mem_read_en", mem_read_en, e_rd);
        chk("mem_write_en", mem_write_en, e_wr);
        if (e_rd || e_wr) chk("mem_addr0", mem_addr0, iss_addr);
        if (e_wr) chk("mem_in", mem_in, iss_data);
        chk("busy", busy, cyc < m_free);
        if (post_rst) begin
            chk("rst_resp_valid", resp_valid, 2'b00);
            chk("rst_resp_err", resp_err, 1'b0);
            chk("rst_resp_rdata", resp_rdata, '0);
        end
        post_rst = rst;
        if (rst) begin
            while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
            m_free = cyc + 1;
            m_last = 1;
            return;
        end
        exp_ready = 2'b00;
        g = 0;
        if (cyc >= m_free && req_valid != 2'b00) begin
            if (req_valid == 2'b11) g = (m_last == 0) ? 1 : 0;
            else g = req_valid[1] ? 1 : 0;
            exp_ready = (g == 1) ? 2'b10 : 2'b01;
        end
        chk("req_ready", req_ready, exp_ready);
        if (exp_ready != 2'b00) begin
            exp_t e;
            acc[g]  = 1'b1;
            m_last  = g;
            e.port  = g;
            e.is_rd = !wr[g];
            e.data  = '0;
            if (32'(ad[g]) >= SIZE) begin
                e.err  = 1'b1;
                e.due  = cyc + 1;
                m_free = cyc + 2;
            end else begin
                e.err    = 1'b0;
                e.due    = cyc + 3;
                m_free   = cyc + 4;
                iss_cyc  = cyc + 1;
                iss_wr   = wr[g];
                iss_addr = ad[g];
                iss_data = wd[g];
                if (wr[g]) ref_mem[ad[g]] = wd[g];
                e.data = ref_mem[ad[g]];
            end
            sb.push_back(e);
        end
    endtask

    // mode 0: both ports always valid; 1: port 1 only; 2: random with resets; 3: hold preset only
    task automatic run_phase(input int mode, input int ncyc);
        for (int n = 0; n < ncyc; n++) begin
            bit rst_now;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) act[i] = 1'b0;
                acc[i] = 1'b0;
                if (!act[i]) begin
                    if (want(i, mode)) begin
                        act[i] = 1'b1;
                        wr[i]  = $urandom_range(1);
                        ad[i]  = (mode == 2) ? IDX'($urandom_range(15)) : IDX'($urandom_range(SIZE - 1));
                        wd[i]  = $urandom;
                    end
                end else if (mode == 2 && $urandom_range(15) == 0) begin
                    act[i] = 1'b0;
                end
            end
            rst_now = 1'b0;
            if (mode == 2) begin
                if (cyc == iss_cyc + 1) rst_now = ($urandom_range(3) == 0);
                else rst_now = ($urandom_range(59) == 0);
            end
            reset = rst_now;
            drive();
            #1;
            model_step(rst_now);
        end
    endtask

    task automatic preset(input int i, input bit w, input int a, input logic [WIDTH-1:0] d);
        act[i] = 1'b1;
        wr[i]  = w;
        ad[i]  = IDX'(a);
        wd[i]  = d;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    logic [WIDTH-1:0] mon_held = '0;
    initial begin
        forever begin
            @(negedge clk);
            chk("rd_wr_exclusive", mem_read_en & mem_write_en, 1'b0);
            if (resp_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got resp_valid=%b expected none at cycle %0d", resp_valid, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_port", resp_valid, (e.port == 1) ? 2'b10 : 2'b01);
                    chk("resp_cycle", cyc, e.due);
                    chk("resp_err", resp_err, e.err);
                    if (e.is_rd && !e.err) mon_held = e.data;
                    chk("resp_rdata", resp_rdata, mon_held);
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                checks++;
                errors++;
                $display("FAIL missing_resp: got none expected port %0d by cycle %0d", sb[0].port, sb[0].due);
                void'(sb.pop_front());
            end
            if (reset) mon_held = '0;
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
        ref_mem[3] = 32'hDEADBEEF;
        for (int i = 0; i < 16; i++) mem[i] = ref_mem[i];
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; acc[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; wd[i] = '0;
        end
        drive();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_req_ready", req_ready, 2'b00);
        chk("reset_resp_valid", resp_valid, 2'b00);
        chk("reset_resp_err", resp_err, 1'b0);
        chk("reset_resp_rdata", resp_rdata, '0);
        chk("reset_mem_en", {mem_read_en, mem_write_en}, 2'b00);
        chk("reset_mem_addr0", mem_addr0, '0);
        chk("reset_mem_in", mem_in, '0);
        chk("reset_busy", busy, 1'b0);

        // Release reset inside the first phase cycle; port 0 must win first.
        run_phase(0, 40);
        run_phase(3, 8);
        preset(0, 1'b0, 3, '0);
        run_phase(3, 6);
        preset(1, 1'b1, 7, 32'h12345678);
        run_phase(3, 6);
        preset(1, 1'b0, 7, '0);
        run_phase(3, 6);
        preset(1, 1'b0, 15, '0);
        run_phase(3, 4);
        run_phase(1, 24);
        run_phase(3, 6);
        run_phase(2, 800);
        run_phase(3, 12);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending responses expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
